// File: rtl/bridge_arbiter_if.sv
// -----------------------------------------------------------------------------
// bridge_arbiter_if
// Bundles every handshake/bus signal around the two-master MMIO bridge
// arbiter: the two master request/response channels (m0 = CPU data port,
// m1 = DMA/debug) and the single downstream bridge port.
//   slave  modport : seen by the arbiter (master requests in, responses out,
//                    bridge address/data out, bridge read data/status in)
//   master modport : seen by whatever drives the masters and models the bridge
// -----------------------------------------------------------------------------
interface bridge_arbiter_if;
    // master 0 channel
    logic        m0_req;
    logic [29:0] m0_a;
    logic [31:0] m0_wd;
    logic        m0_we;
    logic [1:0]  m0_em;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rd;
    logic        m0_err;
    // master 1 channel
    logic        m1_req;
    logic [29:0] m1_a;
    logic [31:0] m1_wd;
    logic        m1_we;
    logic [1:0]  m1_em;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rd;
    logic        m1_err;
    // bridge port
    logic [29:0] br_a;
    logic [31:0] br_wd;
    logic        br_we;
    logic [1:0]  br_em;
    logic [31:0] br_rd;
    logic        br_hit;
    logic        br_erq;
    // status
    logic        busy;

    modport slave (
        input  m0_req, m0_a, m0_wd, m0_we, m0_em,
        output m0_gnt, m0_rvalid, m0_rd, m0_err,
        input  m1_req, m1_a, m1_wd, m1_we, m1_em,
        output m1_gnt, m1_rvalid, m1_rd, m1_err,
        output br_a, br_wd, br_we, br_em,
        input  br_rd, br_hit, br_erq,
        output busy
    );

    modport master (
        output m0_req, m0_a, m0_wd, m0_we, m0_em,
        input  m0_gnt, m0_rvalid, m0_rd, m0_err,
        output m1_req, m1_a, m1_wd, m1_we, m1_em,
        input  m1_gnt, m1_rvalid, m1_rd, m1_err,
        input  br_a, br_wd, br_we, br_em,
        output br_rd, br_hit, br_erq,
        input  busy
    );
endinterface

// File: rtl/bridge_arbiter.sv
// -----------------------------------------------------------------------------
// bridge_arbiter
// Shares the single MMIO bridge port (timer window 0x7f00-0x7f1b) between the
// CPU data port (m0) and the DMA/debug master (m1). Every accepted transaction
// runs IDLE (grant + capture) -> ISSUE (bridge access) -> RESP (registered
// response pulse to the owner), so peak throughput is one access per 3 cycles.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : bridge_arbiter_if.slave (m0_*, m1_*, br_*, busy)
// Parameters:
//   FIXED_PRIO  : 0 = round-robin on contention, 1 = m0 always wins
//   ERR_ON_MISS : 1 = bridge miss completes with err=1,
//                 0 = miss completes with err=0 and rd=0
// -----------------------------------------------------------------------------
module bridge_arbiter #(
    parameter bit FIXED_PRIO  = 1'b0,
    parameter bit ERR_ON_MISS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    bridge_arbiter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]  state_q,     state_d;
    logic        owner_q,     owner_d;
    logic        rr_last_q,   rr_last_d;
    logic [29:0] a_q,         a_d;
    logic [31:0] wd_q,        wd_d;
    logic        we_q,        we_d;
    logic [1:0]  em_q,        em_d;
    logic        m0_rvalid_q, m0_rvalid_d;
    logic [31:0] m0_rd_q,     m0_rd_d;
    logic        m0_err_q,    m0_err_d;
    logic        m1_rvalid_q, m1_rvalid_d;
    logic [31:0] m1_rd_q,     m1_rd_d;
    logic        m1_err_q,    m1_err_d;

    logic        grant_s;
    logic        win_s;
    logic [31:0] resp_rd_s;
    logic        resp_err_s;

    // Arbitration: only IDLE accepts; on contention rr_last points at the
    // master served last, so the other one wins (m0 first out of reset).
    always_comb begin
        grant_s = 1'b0;
        win_s   = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.m0_req && bus.m1_req) begin
                grant_s = 1'b1;
                win_s   = FIXED_PRIO ? 1'b0 : ~rr_last_q;
            end else if (bus.m0_req) begin
                grant_s = 1'b1;
                win_s   = 1'b0;
            end else if (bus.m1_req) begin
                grant_s = 1'b1;
                win_s   = 1'b1;
            end else begin
                grant_s = 1'b0;
                win_s   = 1'b0;
            end
        end else begin
            grant_s = 1'b0;
            win_s   = 1'b0;
        end
    end

    // Response shaping: a miss either reports an error or reads as zero.
    always_comb begin
        resp_err_s = bus.br_erq | (ERR_ON_MISS & ~bus.br_hit);
        if (!bus.br_hit && !ERR_ON_MISS) begin
            resp_rd_s = 32'h0000_0000;
        end else begin
            resp_rd_s = bus.br_rd;
        end
    end

    // Next-state logic: capture winner in IDLE, sample bridge in ISSUE,
    // release in RESP. rd/err hold between responses to the same master.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_last_d   = rr_last_q;
        a_d         = a_q;
        wd_d        = wd_q;
        we_d        = we_q;
        em_d        = em_q;
        m0_rvalid_d = 1'b0;
        m0_rd_d     = m0_rd_q;
        m0_err_d    = m0_err_q;
        m1_rvalid_d = 1'b0;
        m1_rd_d     = m1_rd_q;
        m1_err_d    = m1_err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d   = ST_ISSUE;
                    owner_d   = win_s;
                    rr_last_d = win_s;
                    if (win_s) begin
                        a_d  = bus.m1_a;
                        wd_d = bus.m1_wd;
                        we_d = bus.m1_we;
                        em_d = bus.m1_em;
                    end else begin
                        a_d  = bus.m0_a;
                        wd_d = bus.m0_wd;
                        we_d = bus.m0_we;
                        em_d = bus.m0_em;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
                if (owner_q) begin
                    m1_rvalid_d = 1'b1;
                    m1_rd_d     = resp_rd_s;
                    m1_err_d    = resp_err_s;
                end else begin
                    m0_rvalid_d = 1'b1;
                    m0_rd_d     = resp_rd_s;
                    m0_err_d    = resp_err_s;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            rr_last_q   <= 1'b1;
            a_q         <= 30'h0000_0000;
            wd_q        <= 32'h0000_0000;
            we_q        <= 1'b0;
            em_q        <= 2'b00;
            m0_rvalid_q <= 1'b0;
            m0_rd_q     <= 32'h0000_0000;
            m0_err_q    <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m1_rd_q     <= 32'h0000_0000;
            m1_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_last_q   <= rr_last_d;
            a_q         <= a_d;
            wd_q        <= wd_d;
            we_q        <= we_d;
            em_q        <= em_d;
            m0_rvalid_q <= m0_rvalid_d;
            m0_rd_q     <= m0_rd_d;
            m0_err_q    <= m0_err_d;
            m1_rvalid_q <= m1_rvalid_d;
            m1_rd_q     <= m1_rd_d;
            m1_err_q    <= m1_err_d;
        end
    end

    assign bus.m0_gnt    = grant_s & ~win_s;
    assign bus.m1_gnt    = grant_s &  win_s;
    assign bus.m0_rvalid = m0_rvalid_q;
    assign bus.m0_rd     = m0_rd_q;
    assign bus.m0_err    = m0_err_q;
    assign bus.m1_rvalid = m1_rvalid_q;
    assign bus.m1_rd     = m1_rd_q;
    assign bus.m1_err    = m1_err_q;
    // Address/data come straight from the issue registers, which only change
    // on a grant, so they hold their last value outside ISSUE.
    assign bus.br_a      = a_q;
    assign bus.br_wd     = wd_q;
    // we/em are qualified by the state so they are only live during ISSUE.
    assign bus.br_we     = (state_q == ST_ISSUE) & we_q;
    assign bus.br_em     = (state_q == ST_ISSUE) ? em_q : 2'b00;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bridge_arbiter.sv
module tb_bridge_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bridge_arbiter_if ifa ();  // round-robin, error on miss
    bridge_arbiter_if ifb ();  // fixed priority, error on miss
    bridge_arbiter_if ifc ();  // round-robin, miss reads as zero

    bridge_arbiter #(.FIXED_PRIO(1'b0), .ERR_ON_MISS(1'b1)) u_rr (.clk(clk), .reset(reset), .bus(ifa));
    bridge_arbiter #(.FIXED_PRIO(1'b1), .ERR_ON_MISS(1'b1)) u_fx (.clk(clk), .reset(reset), .bus(ifb));
    bridge_arbiter #(.FIXED_PRIO(1'b0), .ERR_ON_MISS(1'b0)) u_nm (.clk(clk), .reset(reset), .bus(ifc));

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        ifa.m0_req = 1'b0; ifa.m0_a = 30'h0; ifa.m0_wd = 32'h0; ifa.m0_we = 1'b0; ifa.m0_em = 2'b00;
        ifa.m1_req = 1'b0; ifa.m1_a = 30'h0; ifa.m1_wd = 32'h0; ifa.m1_we = 1'b0; ifa.m1_em = 2'b00;
        ifa.br_rd = 32'h0; ifa.br_hit = 1'b1; ifa.br_erq = 1'b0;
        ifb.m0_req = 1'b0; ifb.m0_a = 30'h0; ifb.m0_wd = 32'h0; ifb.m0_we = 1'b0; ifb.m0_em = 2'b00;
        ifb.m1_req = 1'b0; ifb.m1_a = 30'h0; ifb.m1_wd = 32'h0; ifb.m1_we = 1'b0; ifb.m1_em = 2'b00;
        ifb.br_rd = 32'h0; ifb.br_hit = 1'b1; ifb.br_erq = 1'b0;
        ifc.m0_req = 1'b0; ifc.m0_a = 30'h0; ifc.m0_wd = 32'h0; ifc.m0_we = 1'b0; ifc.m0_em = 2'b00;
        ifc.m1_req = 1'b0; ifc.m1_a = 30'h0; ifc.m1_wd = 32'h0; ifc.m1_we = 1'b0; ifc.m1_em = 2'b00;
        ifc.br_rd = 32'h0; ifc.br_hit = 1'b1; ifc.br_erq = 1'b0;

        // ---- reset state
        repeat (3) @(negedge clk);
        #1;
        chk1("rst_busy",      ifa.busy,      1'b0);
        chk1("rst_m0_rvalid", ifa.m0_rvalid, 1'b0);
        chk1("rst_m1_rvalid", ifa.m1_rvalid, 1'b0);
        chkv("rst_m0_rd",     ifa.m0_rd,     32'h0);
        chk1("rst_m0_err",    ifa.m0_err,    1'b0);
        chk1("rst_br_we",     ifa.br_we,     1'b0);
        chkv("rst_br_em",     {30'h0, ifa.br_em}, 32'h0);
        chkv("rst_br_a",      {2'b00, ifa.br_a},  32'h0);

        // ---- single read by m0: 0x7f04 >> 2 = 0x1fc1
        @(negedge clk);
        reset = 1'b0;
        ifa.m0_req = 1'b1; ifa.m0_a = 30'h1fc1; ifa.m0_we = 1'b0;
        ifa.br_rd = 32'h0000_1234; ifa.br_hit = 1'b1; ifa.br_erq = 1'b0;
        #1;
        chk1("rd_m0_gnt",  ifa.m0_gnt, 1'b1);
        chk1("rd_m1_gnt",  ifa.m1_gnt, 1'b0);
        chk1("rd_busy_t0", ifa.busy,   1'b0);
        @(negedge clk);
        ifa.m0_req = 1'b0; ifa.m0_a = 30'h3fff;  // post-grant change must not matter
        #1;
        chk1("rd_busy_t1", ifa.busy,  1'b1);
        chk1("rd_br_we",   ifa.br_we, 1'b0);
        chkv("rd_br_a",    {2'b00, ifa.br_a}, 32'h0000_1fc1);
        chk1("rd_gnt_t1",  ifa.m0_gnt, 1'b0);
        @(negedge clk);
        #1;
        chk1("rd_rvalid",    ifa.m0_rvalid, 1'b1);
        chkv("rd_rd",        ifa.m0_rd,     32'h0000_1234);
        chk1("rd_err",       ifa.m0_err,    1'b0);
        chk1("rd_m1_rvalid", ifa.m1_rvalid, 1'b0);
        @(negedge clk);
        #1;
        chk1("rd_busy_t3",   ifa.busy,      1'b0);
        chk1("rd_rvalid_t3", ifa.m0_rvalid, 1'b0);
        chkv("rd_rd_hold",   ifa.m0_rd,     32'h0000_1234);

        // ---- m1 write to RO register: 0x7f08 >> 2 = 0x1fc2, bridge returns erq
        @(negedge clk);
        ifa.m1_req = 1'b1; ifa.m1_a = 30'h1fc2; ifa.m1_wd = 32'hdead_beef; ifa.m1_we = 1'b1;
        ifa.br_erq = 1'b1;
        #1;
        chk1("wr_m1_gnt", ifa.m1_gnt, 1'b1);
        chk1("wr_m0_gnt", ifa.m0_gnt, 1'b0);
        @(negedge clk);
        ifa.m1_req = 1'b0;
        #1;
        chk1("wr_br_we", ifa.br_we, 1'b1);
        chkv("wr_br_wd", ifa.br_wd, 32'hdead_beef);
        chkv("wr_br_a",  {2'b00, ifa.br_a}, 32'h0000_1fc2);
        @(negedge clk);
        #1;
        chk1("wr_m1_rvalid", ifa.m1_rvalid, 1'b1);
        chk1("wr_m1_err",    ifa.m1_err,    1'b1);
        chk1("wr_m0_rvalid", ifa.m0_rvalid, 1'b0);
        chk1("wr_br_we_resp", ifa.br_we,    1'b0);
        @(negedge clk);
        ifa.br_erq = 1'b0; ifa.m1_we = 1'b0;
        #1;
        chk1("wr_busy_t3", ifa.busy, 1'b0);

        // ---- em pass-through on m0
        @(negedge clk);
        ifa.m0_req = 1'b1; ifa.m0_a = 30'h1fc3; ifa.m0_em = 2'b01; ifa.br_erq = 1'b1;
        #1;
        chk1("em_gnt",     ifa.m0_gnt, 1'b1);
        chkv("em_br_idle", {30'h0, ifa.br_em}, 32'h0);
        @(negedge clk);
        ifa.m0_req = 1'b0; ifa.m0_em = 2'b00;
        #1;
        chkv("em_br_issue", {30'h0, ifa.br_em}, 32'h1);
        @(negedge clk);
        #1;
        chkv("em_br_resp", {30'h0, ifa.br_em}, 32'h0);
        chk1("em_rvalid",  ifa.m0_rvalid, 1'b1);
        chk1("em_err",     ifa.m0_err,    1'b1);
        @(negedge clk);
        ifa.br_erq = 1'b0;

        // ---- miss: 0x1000 >> 2 = 0x400, with and without error-on-miss
        @(negedge clk);
        ifa.m0_req = 1'b1; ifa.m0_a = 30'h400; ifa.br_hit = 1'b0; ifa.br_rd = 32'hcafe_f00d;
        ifc.m0_req = 1'b1; ifc.m0_a = 30'h400; ifc.br_hit = 1'b0; ifc.br_rd = 32'hcafe_f00d;
        #1;
        chk1("miss_gnt_a", ifa.m0_gnt, 1'b1);
        chk1("miss_gnt_c", ifc.m0_gnt, 1'b1);
        @(negedge clk);
        ifa.m0_req = 1'b0; ifc.m0_req = 1'b0;
        @(negedge clk);
        #1;
        chk1("miss_rvalid_a", ifa.m0_rvalid, 1'b1);
        chk1("miss_err_a",    ifa.m0_err,    1'b1);
        chk1("miss_rvalid_c", ifc.m0_rvalid, 1'b1);
        chk1("miss_err_c",    ifc.m0_err,    1'b0);
        chkv("miss_rd_c",     ifc.m0_rd,     32'h0);
        @(negedge clk);
        ifa.br_hit = 1'b1; ifc.br_hit = 1'b1;

        // ---- contention for 12 cycles, starting from reset priority
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ifa.m0_req = 1'b1; ifa.m1_req = 1'b1; ifa.m0_a = 30'h1fc0; ifa.m1_a = 30'h1fc4;
        ifb.m0_req = 1'b1; ifb.m1_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk1($sformatf("rr_m0_gnt_c%0d", i), ifa.m0_gnt, (i % 3 == 0) && ((i / 3) % 2 == 0));
            chk1($sformatf("rr_m1_gnt_c%0d", i), ifa.m1_gnt, (i % 3 == 0) && ((i / 3) % 2 == 1));
            chk1($sformatf("fx_m0_gnt_c%0d", i), ifb.m0_gnt, (i % 3 == 0));
            chk1($sformatf("fx_m1_gnt_c%0d", i), ifb.m1_gnt, 1'b0);
        end
        @(negedge clk);
        ifa.m0_req = 1'b0; ifa.m1_req = 1'b0;
        ifb.m0_req = 1'b0; ifb.m1_req = 1'b0;
        #1;
        chk1("rr_idle_end", ifa.busy, 1'b0);

        // ---- reset during ISSUE of an m0 write
        @(negedge clk);
        ifa.m0_req = 1'b1; ifa.m0_a = 30'h1fc5; ifa.m0_wd = 32'h0000_00aa; ifa.m0_we = 1'b1;
        ifa.br_rd = 32'h0000_5a5a;
        #1;
        chk1("rst_iss_gnt", ifa.m0_gnt, 1'b1);
        @(negedge clk);
        ifa.m0_req = 1'b0; ifa.m0_we = 1'b0;
        reset = 1'b1;
        #1;
        chk1("rst_iss_busy",  ifa.busy,  1'b1);
        chk1("rst_iss_br_we", ifa.br_we, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        ifa.m1_req = 1'b1; ifa.m1_a = 30'h1fc6; ifa.m1_we = 1'b0;
        #1;
        chk1("rst_iss_no_rvalid", ifa.m0_rvalid, 1'b0);
        chk1("rst_iss_idle",      ifa.busy,      1'b0);
        chk1("rst_iss_we_drop",   ifa.br_we,     1'b0);
        chkv("rst_iss_br_a",      {2'b00, ifa.br_a}, 32'h0);
        chkv("rst_iss_m0_rd",     ifa.m0_rd,     32'h0);
        chk1("rst_iss_m1_gnt",    ifa.m1_gnt,    1'b1);
        @(negedge clk);
        ifa.m1_req = 1'b0;
        #1;
        chkv("rst_iss_m1_br_a", {2'b00, ifa.br_a}, 32'h0000_1fc6);
        @(negedge clk);
        #1;
        chk1("rst_iss_m1_rvalid", ifa.m1_rvalid, 1'b1);
        chkv("rst_iss_m1_rd",     ifa.m1_rd,     32'h0000_5a5a);
        chk1("rst_iss_m0_quiet",  ifa.m0_rvalid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
